// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter and sequencer for a single-port data memory.
// Defining MEM_ARB_CNT_EN adds per-requester grant counters; otherwise gnt_cnt0/1 are tied to 0.
module mem_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int MEM_WIDTH  = 4,
   parameter int PRIO_RR    = 1,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clka,
   input  logic                  reset,
   input  logic                  r0_req,
   input  logic                  r0_we,
   input  logic [MEM_WIDTH-1:0]  r0_addr,
   input  logic [DATA_WIDTH-1:0] r0_wdata,
   output logic                  r0_gnt,
   output logic                  r0_rvalid,
   output logic [DATA_WIDTH-1:0] r0_rdata,
   input  logic                  r1_req,
   input  logic                  r1_we,
   input  logic [MEM_WIDTH-1:0]  r1_addr,
   input  logic [DATA_WIDTH-1:0] r1_wdata,
   output logic                  r1_gnt,
   output logic                  r1_rvalid,
   output logic [DATA_WIDTH-1:0] r1_rdata,
   output logic                  mem_clkEnable,
   output logic                  mem_wea,
   output logic [MEM_WIDTH-1:0]  mem_addra,
   output logic [DATA_WIDTH-1:0] mem_dina,
   input  logic [DATA_WIDTH-1:0] mem_douta,
   output logic [CNT_WIDTH-1:0]  gnt_cnt0,
   output logic [CNT_WIDTH-1:0]  gnt_cnt1
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;

   logic                  r_owner;
   logic                  r_last_winner;
   logic                  r_we_q;
   logic [MEM_WIDTH-1:0]  r_mem_addra;
   logic [DATA_WIDTH-1:0] r_mem_dina;
   logic [DATA_WIDTH-1:0] r_rdata0;
   logic [DATA_WIDTH-1:0] r_rdata1;
   logic                  r_mem_ce;
   logic                  r_mem_wea;
   logic                  r_gnt0;
   logic                  r_gnt1;
   logic                  r_rvalid0;
   logic                  r_rvalid1;

   logic                  w_any_req;
   logic                  w_winner;
   logic                  w_win_we;
   logic [MEM_WIDTH-1:0]  w_win_addr;
   logic [DATA_WIDTH-1:0] w_win_wdata;
   logic                  w_load;
   logic                  w_capture;
   logic                  w_mem_ce_nxt;
   logic                  w_mem_wea_nxt;
   logic                  w_gnt0_nxt;
   logic                  w_gnt1_nxt;
   logic                  w_rvalid0_nxt;
   logic                  w_rvalid1_nxt;

   // Winner selection: a lone requester wins outright; a tie goes by PRIO_RR.
   always_comb begin
      w_any_req = r0_req | r1_req;
      if (r0_req && r1_req) begin
         w_winner = (PRIO_RR != 0) ? ~r_last_winner : 1'b0;
      end else begin
         w_winner = r1_req;
      end
      w_win_we    = w_winner ? r1_we    : r0_we;
      w_win_addr  = w_winner ? r1_addr  : r0_addr;
      w_win_wdata = w_winner ? r1_wdata : r0_wdata;
   end

   // NOTE: every output of this block gets a default before the case, so no path
   // leaves a signal unassigned and no latch is inferred.
   always_comb begin
      w_state_nxt   = r_state;
      w_load        = 1'b0;
      w_capture     = 1'b0;
      w_mem_ce_nxt  = 1'b0;
      w_mem_wea_nxt = 1'b0;
      w_gnt0_nxt    = 1'b0;
      w_gnt1_nxt    = 1'b0;
      w_rvalid0_nxt = 1'b0;
      w_rvalid1_nxt = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_any_req) begin
               w_state_nxt   = S_ISSUE;
               w_load        = 1'b1;
               w_mem_ce_nxt  = 1'b1;
               w_mem_wea_nxt = w_win_we;
               w_gnt0_nxt    = ~w_winner;
               w_gnt1_nxt    = w_winner;
            end
         end
         S_ISSUE: begin
            w_state_nxt   = S_DONE;
            w_capture     = ~r_we_q;
            w_rvalid0_nxt = ~r_owner;
            w_rvalid1_nxt = r_owner;
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clka or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Handshake and memory strobes are registered one state ahead, so they are glitch-free.
   always_ff @(posedge clka or posedge reset) begin
      if (reset) begin
         r_mem_ce  <= 1'b0;
         r_mem_wea <= 1'b0;
         r_gnt0    <= 1'b0;
         r_gnt1    <= 1'b0;
         r_rvalid0 <= 1'b0;
         r_rvalid1 <= 1'b0;
      end else begin
         r_mem_ce  <= w_mem_ce_nxt;
         r_mem_wea <= w_mem_wea_nxt;
         r_gnt0    <= w_gnt0_nxt;
         r_gnt1    <= w_gnt1_nxt;
         r_rvalid0 <= w_rvalid0_nxt;
         r_rvalid1 <= w_rvalid1_nxt;
      end
   end

   // NOTE: these are plain registers, not a memory array, so all of them are cleared by reset.
   always_ff @(posedge clka or posedge reset) begin
      if (reset) begin
         r_owner       <= 1'b0;
         r_last_winner <= 1'b1;
         r_we_q        <= 1'b0;
         r_mem_addra   <= '0;
         r_mem_dina    <= '0;
         r_rdata0      <= '0;
         r_rdata1      <= '0;
      end else begin
         if (w_load) begin
            r_owner       <= w_winner;
            r_last_winner <= w_winner;
            r_we_q        <= w_win_we;
            r_mem_addra   <= w_win_addr;
            r_mem_dina    <= w_win_wdata;
         end
         if (w_capture) begin
            if (r_owner) begin
               r_rdata1 <= mem_douta;
            end else begin
               r_rdata0 <= mem_douta;
            end
         end
      end
   end

`ifdef MEM_ARB_CNT_EN
   logic [CNT_WIDTH-1:0] r_cnt0;
   logic [CNT_WIDTH-1:0] r_cnt1;

   // One increment per ISSUE cycle of the owner; natural wrap at 2**CNT_WIDTH.
   always_ff @(posedge clka or posedge reset) begin
      if (reset) begin
         r_cnt0 <= '0;
         r_cnt1 <= '0;
      end else if (r_state == S_ISSUE) begin
         if (r_owner) begin
            r_cnt1 <= r_cnt1 + CNT_WIDTH'(1);
         end else begin
            r_cnt0 <= r_cnt0 + CNT_WIDTH'(1);
         end
      end
   end

   assign gnt_cnt0 = r_cnt0;
   assign gnt_cnt1 = r_cnt1;
`else
   assign gnt_cnt0 = '0;
   assign gnt_cnt1 = '0;
`endif

   assign r0_gnt        = r_gnt0;
   assign r1_gnt        = r_gnt1;
   assign r0_rvalid     = r_rvalid0;
   assign r1_rvalid     = r_rvalid1;
   assign r0_rdata      = r_rdata0;
   assign r1_rdata      = r_rdata1;
   assign mem_clkEnable = r_mem_ce;
   assign mem_wea       = r_mem_wea;
   assign mem_addra     = r_mem_addra;
   assign mem_dina      = r_mem_dina;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter; a round-robin and a fixed-priority
// instance share stimulus, each with its own behavioural 16x32 memory.
module tb_mem_arbiter;

   localparam int DW = 32;
   localparam int AW = 4;
   localparam int CW = 2;

   logic          clk;
   logic          reset;
   logic          mem_load;
   logic          r0_req, r0_we, r1_req, r1_we;
   logic [AW-1:0] r0_addr, r1_addr;
   logic [DW-1:0] r0_wdata, r1_wdata;

   logic          rr_r0_gnt, rr_r0_rvalid, rr_r1_gnt, rr_r1_rvalid, rr_ce, rr_wea;
   logic [DW-1:0] rr_r0_rdata, rr_r1_rdata, rr_dina, rr_douta;
   logic [AW-1:0] rr_addra;
   logic [CW-1:0] rr_cnt0, rr_cnt1;

   logic          fp_r0_gnt, fp_r0_rvalid, fp_r1_gnt, fp_r1_rvalid, fp_ce, fp_wea;
   logic [DW-1:0] fp_r0_rdata, fp_r1_rdata, fp_dina, fp_douta;
   logic [AW-1:0] fp_addra;
   logic [CW-1:0] fp_cnt0, fp_cnt1;

   logic [DW-1:0] mem_rr [16];
   logic [DW-1:0] mem_fp [16];

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

`ifdef MEM_ARB_CNT_EN
   localparam logic [CW-1:0] EXP_CNT1 = 2'd1;
`else
   localparam logic [CW-1:0] EXP_CNT1 = 2'd0;
`endif

   mem_arbiter #(.DATA_WIDTH(DW), .MEM_WIDTH(AW), .PRIO_RR(1), .CNT_WIDTH(CW)) u_rr (
      .clka(clk), .reset(reset),
      .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
      .r0_gnt(rr_r0_gnt), .r0_rvalid(rr_r0_rvalid), .r0_rdata(rr_r0_rdata),
      .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
      .r1_gnt(rr_r1_gnt), .r1_rvalid(rr_r1_rvalid), .r1_rdata(rr_r1_rdata),
      .mem_clkEnable(rr_ce), .mem_wea(rr_wea), .mem_addra(rr_addra), .mem_dina(rr_dina),
      .mem_douta(rr_douta), .gnt_cnt0(rr_cnt0), .gnt_cnt1(rr_cnt1)
   );

   mem_arbiter #(.DATA_WIDTH(DW), .MEM_WIDTH(AW), .PRIO_RR(0), .CNT_WIDTH(CW)) u_fp (
      .clka(clk), .reset(reset),
      .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
      .r0_gnt(fp_r0_gnt), .r0_rvalid(fp_r0_rvalid), .r0_rdata(fp_r0_rdata),
      .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
      .r1_gnt(fp_r1_gnt), .r1_rvalid(fp_r1_rvalid), .r1_rdata(fp_r1_rdata),
      .mem_clkEnable(fp_ce), .mem_wea(fp_wea), .mem_addra(fp_addra), .mem_dina(fp_dina),
      .mem_douta(fp_douta), .gnt_cnt0(fp_cnt0), .gnt_cnt1(fp_cnt1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural single-port memories: synchronous write, combinational read.
   always @(posedge clk) begin
      if (mem_load) begin
         for (int i = 0; i < 16; i++) begin
            mem_rr[i] <= 32'hA5A5_0000 | DW'(i);
            mem_fp[i] <= 32'hA5A5_0000 | DW'(i);
         end
      end else begin
         if (rr_ce && rr_wea) mem_rr[rr_addra] <= rr_dina;
         if (fp_ce && fp_wea) mem_fp[fp_addra] <= fp_dina;
      end
   end

   assign rr_douta = mem_rr[rr_addra];
   assign fp_douta = mem_fp[fp_addra];

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   // One complete access on the round-robin instance; starts and ends on a negedge.
   task automatic access(input string tag, input bit sel, input bit we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rdata);
      if (!sel) begin
         r0_req = 1'b1; r0_we = we; r0_addr = addr; r0_wdata = wdata;
      end else begin
         r1_req = 1'b1; r1_we = we; r1_addr = addr; r1_wdata = wdata;
      end
      @(negedge clk);
      check({tag, "_gnt"}, sel ? rr_r1_gnt : rr_r0_gnt, 1);
      check({tag, "_gnt_other"}, sel ? rr_r0_gnt : rr_r1_gnt, 0);
      check({tag, "_ce_issue"}, rr_ce, 1);
      check({tag, "_wea_issue"}, rr_wea, we);
      check({tag, "_addra"}, rr_addra, addr);
      r0_req = 1'b0;
      r1_req = 1'b0;
      @(negedge clk);
      check({tag, "_rvalid"}, sel ? rr_r1_rvalid : rr_r0_rvalid, 1);
      check({tag, "_ce_done"}, rr_ce, 0);
      check({tag, "_wea_done"}, rr_wea, 0);
      if (!we) check({tag, "_rdata"}, sel ? rr_r1_rdata : rr_r0_rdata, exp_rdata);
      @(negedge clk);
   endtask

   initial begin
      int rr_order [4];
      int rr_n;
      int fp_n0;
      int fp_n1;

      reset = 1'b1; mem_load = 1'b1;
      r0_req = 1'b0; r0_we = 1'b0; r0_addr = '0; r0_wdata = '0;
      r1_req = 1'b0; r1_we = 1'b0; r1_addr = '0; r1_wdata = '0;
      @(negedge clk);
      check("rst_gnt", {30'd0, rr_r0_gnt, rr_r1_gnt}, 0);
      check("rst_rvalid", {30'd0, rr_r0_rvalid, rr_r1_rvalid}, 0);
      check("rst_rdata0", rr_r0_rdata, 0);
      check("rst_rdata1", rr_r1_rdata, 0);
      check("rst_mem_ctl", {30'd0, rr_ce, rr_wea}, 0);
      check("rst_addra", rr_addra, 0);
      check("rst_dina", rr_dina, 0);
      check("rst_cnt", {28'd0, rr_cnt0, rr_cnt1}, 0);
      @(negedge clk);
      mem_load = 1'b0;
      reset = 1'b0;
      @(negedge clk);

      // Simultaneous reads: r0 wins the first tie, r1 follows three cycles later.
      r0_req = 1'b1; r0_we = 1'b0; r0_addr = 4'd1;
      r1_req = 1'b1; r1_we = 1'b0; r1_addr = 4'd2;
      @(negedge clk);
      check("sim_r0_gnt", rr_r0_gnt, 1);
      check("sim_r1_gnt_lo", rr_r1_gnt, 0);
      check("sim_addr1", rr_addra, 4'd1);
      r0_req = 1'b0;
      @(negedge clk);
      check("sim_r0_rvalid", rr_r0_rvalid, 1);
      check("sim_r0_rdata", rr_r0_rdata, 32'hA5A5_0001);
      check("sim_r1_rdata_hold", rr_r1_rdata, 0);
      @(negedge clk);
      check("sim_idle_gnt", {30'd0, rr_r0_gnt, rr_r1_gnt}, 0);
      @(negedge clk);
      check("sim_r1_gnt", rr_r1_gnt, 1);
      check("sim_addr2", rr_addra, 4'd2);
      r1_req = 1'b0;
      @(negedge clk);
      check("sim_r1_rvalid", rr_r1_rvalid, 1);
      check("sim_r1_rdata", rr_r1_rdata, 32'hA5A5_0002);
      check("sim_r0_rdata_hold", rr_r0_rdata, 32'hA5A5_0001);
      @(negedge clk);

      // Write then read back through requester 0.
      access("wr0", 1'b0, 1'b1, 4'd3, 32'hDEAD_BEEF, 32'h0);
      check("wr0_dina_hold", rr_dina, 32'hDEAD_BEEF);
      access("rd0", 1'b0, 1'b0, 4'd3, 32'h0, 32'hDEAD_BEEF);

      // Continuous contention for 12 cycles after a fresh reset.
      pulse_reset();
      rr_n = 0; fp_n0 = 0; fp_n1 = 0;
      for (int i = 0; i < 4; i++) rr_order[i] = -1;
      r0_req = 1'b1; r0_we = 1'b0; r0_addr = 4'd4;
      r1_req = 1'b1; r1_we = 1'b0; r1_addr = 4'd5;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (rr_r0_gnt || rr_r1_gnt) begin
            if (rr_n < 4) rr_order[rr_n] = rr_r1_gnt ? 1 : 0;
            rr_n++;
         end
         if (fp_r0_gnt) fp_n0++;
         if (fp_r1_gnt) fp_n1++;
      end
      r0_req = 1'b0; r1_req = 1'b0;
      check("rr_grant_count", rr_n, 4);
      check("rr_order0", rr_order[0], 0);
      check("rr_order1", rr_order[1], 1);
      check("rr_order2", rr_order[2], 0);
      check("rr_order3", rr_order[3], 1);
      check("fp_r0_grants", fp_n0, 4);
      check("fp_r1_grants", fp_n1, 0);
      @(negedge clk);
      @(negedge clk);

      // Reset during ISSUE of an r1 write aborts the transaction.
      r1_req = 1'b1; r1_we = 1'b1; r1_addr = 4'd5; r1_wdata = 32'h1234_5678;
      @(negedge clk);
      check("abort_r1_gnt", rr_r1_gnt, 1);
      reset = 1'b1;
      r1_req = 1'b0;
      #1;
      check("abort_gnt", {30'd0, rr_r0_gnt, rr_r1_gnt}, 0);
      check("abort_mem_ctl", {30'd0, rr_ce, rr_wea}, 0);
      check("abort_addra", rr_addra, 0);
      check("abort_dina", rr_dina, 0);
      @(negedge clk);
      reset = 1'b0;
      check("abort_no_rvalid_a", rr_r1_rvalid, 0);
      @(negedge clk);
      check("abort_no_rvalid_b", rr_r1_rvalid, 0);
      r0_req = 1'b1; r0_we = 1'b0; r0_addr = 4'd6;
      r1_req = 1'b1; r1_we = 1'b0; r1_addr = 4'd7;
      @(negedge clk);
      check("abort_tie_r0", rr_r0_gnt, 1);
      check("abort_tie_r1_lo", rr_r1_gnt, 0);
      r0_req = 1'b0; r1_req = 1'b0;
      @(negedge clk);
      @(negedge clk);

      // Five r1 grants: a 2-bit counter wraps to 1 when enabled, stays 0 otherwise.
      pulse_reset();
      for (int k = 0; k < 5; k++) begin
         access("cnt_rd1", 1'b1, 1'b0, AW'(8 + k), 32'h0, 32'hA5A5_0008 + DW'(k));
      end
      check("cnt1_rr", rr_cnt1, EXP_CNT1);
      check("cnt0_rr", rr_cnt0, 0);
      check("cnt1_fp", fp_cnt1, EXP_CNT1);
      check("cnt0_fp", fp_cnt0, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
